load_store_unit: RTL and testbench

- Sits directly downstream of the RV32I datapath, between its address/store-data outputs and the data-memory bus.
- Turns the core's single-cycle load/store request into a valid/ready bus transaction, stalling the core until the transaction completes.
- Generates byte strobes for SB/SH/SW, extracts and sign-/zero-extends load data for LB/LH/LW/LBU/LHU, and flags misaligned, illegal and timed-out accesses.

---
 rtl/load_store_unit.sv | 183 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: converts single-cycle core load/store requests into a
// valid/ready bus transaction, stalling the core until it completes or faults.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        bus_valid,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_strobe,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_count;
  logic [1:0]         r_addr_lo;
  logic [2:0]         r_funct3;
  logic               r_bus_write;
  logic [31:0]        r_bus_address;
  logic [31:0]        r_bus_wdata;
  logic [3:0]         r_bus_strobe;
  logic [31:0]        r_read_data;
  logic               r_fault;
  logic [1:0]         r_cause;

  logic               w_req, w_illegal, w_misaligned, w_start, w_timeout;
  logic [3:0]         w_strobe;
  logic [31:0]        w_wdata;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load;

  // Request decode; illegal encodings outrank misalignment
  always_comb begin
    w_req        = mem_read | mem_write;
    w_illegal    = (mem_read & mem_write)
                 | (mem_read  & !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
                 | (mem_write & !(funct3 inside {3'b000, 3'b001, 3'b010}));
    w_misaligned = ((funct3[1:0] == 2'b01) & address[0])
                 | ((funct3[1:0] == 2'b10) & (address[1:0] != 2'b00));
    w_start      = (r_state == S_IDLE) & w_req & !w_illegal & !w_misaligned;
    w_timeout    = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Store lane strobes and replicated data
  always_comb begin
    w_strobe = 4'b1111;
    w_wdata  = write_data;
    case (funct3[1:0])
      2'b00: begin
        w_strobe = 4'b0001 << address[1:0];
        w_wdata  = {4{write_data[7:0]}};
      end
      2'b01: begin
        w_strobe = 4'b0011 << {address[1], 1'b0};
        w_wdata  = {2{write_data[15:0]}};
      end
      default: ;
    endcase
    if (!mem_write) w_strobe = 4'b0000;
  end

  // Load lane select and extension
  always_comb begin
    w_byte = bus_rdata[8*r_addr_lo +: 8];
    w_half = r_addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = bus_rdata;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_next = S_REQUEST;
      S_REQUEST: if (bus_ready || w_timeout) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    fault       = 1'b0;
    fault_cause = 2'b00;
    bus_valid   = 1'b0;
    read_data   = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_req && (w_illegal || w_misaligned)) begin
          fault       = 1'b1;
          fault_cause = w_illegal ? 2'b10 : 2'b01;
        end
        stall = w_start;
      end
      S_REQUEST: begin
        stall     = 1'b1;
        bus_valid = 1'b1;
      end
      S_DONE: begin
        fault       = r_fault;
        fault_cause = r_cause;
        read_data   = r_read_data;
      end
      default: ;
    endcase
  end

  // Request latch, timeout counter and completion capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count       <= '0;
      r_addr_lo     <= 2'b00;
      r_funct3      <= 3'b000;
      r_bus_write   <= 1'b0;
      r_bus_address <= 32'd0;
      r_bus_wdata   <= 32'd0;
      r_bus_strobe  <= 4'b0000;
      r_read_data   <= 32'd0;
      r_fault       <= 1'b0;
      r_cause       <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_count       <= '0;
            r_addr_lo     <= address[1:0];
            r_funct3      <= funct3;
            r_bus_write   <= mem_write;
            r_bus_address <= {address[31:2], 2'b00};
            r_bus_wdata   <= w_wdata;
            r_bus_strobe  <= w_strobe;
          end
        end
        S_REQUEST: begin
          r_count <= r_count + CNT_W'(1);
          if (bus_ready) begin
            r_read_data <= r_bus_write ? 32'd0 : w_load;
            r_fault     <= 1'b0;
            r_cause     <= 2'b00;
          end else if (w_timeout) begin
            r_read_data <= 32'd0;
            r_fault     <= 1'b1;
            r_cause     <= 2'b11;
          end
        end
        S_DONE:  r_count <= '0;
        default: ;
      endcase
    end
  end

  assign bus_write   = r_bus_write;
  assign bus_address = r_bus_address;
  assign bus_wdata   = r_bus_wdata;
  assign bus_strobe  = r_bus_strobe;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (timeout shortened to 4).
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        stall, fault;
  logic [1:0]  fault_cause;
  logic        bus_valid, bus_write;
  logic [31:0] bus_address, bus_wdata;
  logic [3:0]  bus_strobe;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  // Observations captured by the access task
  int          o_stall_cnt;
  logic        o_valid, o_write;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_strobe;
  logic [31:0] o_rd;
  logic        o_fault, o_stall_done, o_valid_done;
  logic [1:0]  o_cause;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .address(address), .write_data(write_data),
    .read_data(read_data), .stall(stall), .fault(fault), .fault_cause(fault_cause),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_address(bus_address),
    .bus_wdata(bus_wdata), .bus_strobe(bus_strobe),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int waits);
    mem_read = rd; mem_write = wr; funct3 = f3; address = addr; write_data = wd;
    bus_ready = 1'b0; bus_rdata = 32'h0;
    #1;
    o_stall_cnt = 0;
    if (stall) o_stall_cnt++;
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    o_valid = bus_valid; o_write = bus_write; o_addr = bus_address;
    o_wdata = bus_wdata; o_strobe = bus_strobe;
    for (int i = 0; i < waits; i++) begin
      if (stall) o_stall_cnt++;
      bus_rdata = 32'hA5A5A5A5;
      tick();
    end
    if (stall) o_stall_cnt++;
    bus_ready = 1'b1; bus_rdata = rdata;
    tick();
    bus_ready = 1'b0; bus_rdata = 32'h5A5A5A5A;
    o_rd = read_data; o_fault = fault; o_cause = fault_cause;
    o_stall_done = stall; o_valid_done = bus_valid;
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    address = 32'h0; write_data = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
    #12;
    chk("rst_valid",  32'(bus_valid), 32'h0);
    chk("rst_stall",  32'(stall), 32'h0);
    chk("rst_addr",   bus_address, 32'h0);
    chk("rst_rdata",  read_data, 32'h0);
    chk("rst_strobe", 32'(bus_strobe), 32'h0);
    reset = 1'b0;
    tick();

    // LW with two wait states
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    chk("lw_valid",  32'(o_valid), 32'h1);
    chk("lw_addr",   o_addr, 32'h100);
    chk("lw_strobe", 32'(o_strobe), 32'h0);
    chk("lw_write",  32'(o_write), 32'h0);
    chk("lw_stalls", 32'(o_stall_cnt), 32'd4);
    chk("lw_rdata",  o_rd, 32'hDEADBEEF);
    chk("lw_fault",  32'(o_fault), 32'h0);
    chk("lw_done_stall", 32'(o_stall_done), 32'h0);
    chk("lw_done_valid", 32'(o_valid_done), 32'h0);

    // Sub-word loads, zero wait states
    access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 0);
    chk("lb_rdata",  o_rd, 32'hFFFFFF80);
    chk("lb_stalls", 32'(o_stall_cnt), 32'd2);
    access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 0);
    chk("lbu_rdata", o_rd, 32'h00000080);
    access(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'h80FF1234, 0);
    chk("lhu_rdata", o_rd, 32'h000080FF);
    access(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h80FF1234, 0);
    chk("lh_rdata",  o_rd, 32'hFFFF80FF);
    access(1'b1, 1'b0, 3'b000, 32'h201, 32'h0, 32'h80FF1234, 1);
    chk("lb1_rdata", o_rd, 32'h00000012);

    // Stores
    access(1'b0, 1'b1, 3'b000, 32'h301, 32'h000000AB, 32'hFFFFFFFF, 0);
    chk("sb_addr",   o_addr, 32'h300);
    chk("sb_strobe", 32'(o_strobe), 32'h2);
    chk("sb_wdata",  o_wdata, 32'hABABABAB);
    chk("sb_write",  32'(o_write), 32'h1);
    chk("sb_rdata",  o_rd, 32'h0);
    access(1'b0, 1'b1, 3'b001, 32'h302, 32'h1234ABCD, 32'h0, 0);
    chk("sh_strobe", 32'(o_strobe), 32'hC);
    chk("sh_wdata",  o_wdata, 32'hABCDABCD);
    access(1'b0, 1'b1, 3'b010, 32'h304, 32'hCAFEF00D, 32'h0, 0);
    chk("sw_strobe", 32'(o_strobe), 32'hF);
    chk("sw_wdata",  o_wdata, 32'hCAFEF00D);

    // Misaligned LW faults combinationally, no bus activity
    mem_read = 1'b1; funct3 = 3'b010; address = 32'h102;
    #1;
    chk("mis_stall", 32'(stall), 32'h0);
    chk("mis_fault", 32'(fault), 32'h1);
    chk("mis_cause", 32'(fault_cause), 32'h1);
    chk("mis_rdata", read_data, 32'h0);
    tick();
    chk("mis_valid", 32'(bus_valid), 32'h0);
    // Read and write together
    mem_write = 1'b1; address = 32'h100;
    #1;
    chk("rw_cause", 32'(fault_cause), 32'h2);
    chk("rw_stall", 32'(stall), 32'h0);
    // Illegal store funct3 plus misalignment: illegal wins
    mem_read = 1'b0; funct3 = 3'b011; address = 32'h101;
    #1;
    chk("ill_cause", 32'(fault_cause), 32'h2);
    // Illegal load funct3
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b110; address = 32'h100;
    #1;
    chk("illld_cause", 32'(fault_cause), 32'h2);
    tick();
    chk("ill_valid", 32'(bus_valid), 32'h0);
    mem_read = 1'b0;
    tick();

    // Timeout with bus_ready held low
    mem_read = 1'b1; funct3 = 3'b010; address = 32'h400; bus_ready = 1'b0;
    tick();
    mem_read = 1'b0;
    n = 0;
    while (bus_valid && n < 20) begin
      n++;
      tick();
    end
    chk("to_valid_cycles", 32'(n), 32'd4);
    chk("to_fault", 32'(fault), 32'h1);
    chk("to_cause", 32'(fault_cause), 32'h3);
    chk("to_rdata", read_data, 32'h0);
    chk("to_stall", 32'(stall), 32'h0);
    tick();
    chk("to_idle_fault", 32'(fault), 32'h0);

    // Reset mid-REQUEST
    mem_read = 1'b1; funct3 = 3'b010; address = 32'h500;
    tick();
    mem_read = 1'b0;
    chk("mr_valid_before", 32'(bus_valid), 32'h1);
    reset = 1'b1;
    #1;
    chk("mr_valid", 32'(bus_valid), 32'h0);
    chk("mr_stall", 32'(stall), 32'h0);
    chk("mr_rdata", read_data, 32'h0);
    chk("mr_addr",  bus_address, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    access(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h13579BDF, 1);
    chk("post_addr",  o_addr, 32'h600);
    chk("post_rdata", o_rd, 32'h13579BDF);
    chk("post_fault", 32'(o_fault), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
